// File: rtl/predictor_update_sched.sv
// Write-port scheduler for the branch-predictor tables: buffers resolved-branch updates in a FIFO
// and runs a clear sweep after reset or flush. Define PRED_UPD_STATS_EN to enable retire/mispredict counters.
module predictor_update_sched #(
  parameter int DEPTH     = 4,
  parameter int IP_W      = 16,
  parameter int TABLE_IDX = 12
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic                 res_valid,
  input  logic [IP_W-1:0]      res_ip,
  input  logic                 res_taken,
  input  logic                 res_pl,
  input  logic                 res_pg,
  input  logic                 res_pred,
  output logic                 res_ready,
  input  logic                 flush_req,
  input  logic                 upd_stall,
  output logic                 upd_valid,
  output logic [IP_W-1:0]      upd_ip,
  output logic                 upd_taken,
  output logic                 upd_meta_en,
  output logic                 upd_meta_inc,
  output logic                 clr_valid,
  output logic [TABLE_IDX-1:0] clr_idx,
  output logic                 busy,
  output logic [15:0]          stat_upd,
  output logic [15:0]          stat_misp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];
  localparam int ENT_W = IP_W + 3;

  typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  head;
  logic              push, pop;

  always_comb begin
    state_nxt = state;
    res_ready = 1'b0;
    clr_valid = 1'b0;
    case (state)
      CLEAR: begin
        clr_valid = 1'b1;
        if (&clr_idx) state_nxt = RUN;
      end
      RUN: begin
        res_ready = (count < DEPTH_C);
        if (flush_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (count == '0) state_nxt = CLEAR;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign busy      = (state != RUN);
  assign upd_valid = (count != '0) && (state != CLEAR);
  assign push      = res_valid && res_ready;
  assign pop       = upd_valid && !upd_stall;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= CLEAR;
      clr_idx <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_idx <= (&clr_idx) ? '0 : clr_idx + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= {res_ip, res_taken, res_pl ^ res_pg, res_pg == res_taken};
  end

  assign head         = mem[rd_ptr];
  assign upd_ip       = head[ENT_W-1:3];
  assign upd_taken    = head[2];
  assign upd_meta_en  = head[1];
  assign upd_meta_inc = head[0];

`ifdef PRED_UPD_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      stat_upd  <= '0;
      stat_misp <= '0;
    end else begin
      if (pop) stat_upd <= sat_inc(stat_upd);
      if (push && (res_pred != res_taken)) stat_misp <= sat_inc(stat_misp);
    end
  end
`else
  logic unused_res_pred;
  assign unused_res_pred = res_pred;
  assign stat_upd  = 16'h0;
  assign stat_misp = 16'h0;
`endif

endmodule

// File: tb/tb_predictor_update_sched.sv
// Bench for predictor_update_sched: directed table, hand sequences and random traffic vs a queue model.
module tb_predictor_update_sched;

  localparam int DEPTH = 4;
  localparam int IP_W  = 16;
  localparam int TIDX  = 4;
  localparam int NCLR  = 16;
  localparam int M_CLR = 0, M_RUN = 1, M_DRN = 2;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b1;
  logic res_valid = 1'b0, res_taken = 1'b0, res_pl = 1'b0, res_pg = 1'b0, res_pred = 1'b0;
  logic [IP_W-1:0] res_ip = '0;
  logic flush_req = 1'b0, upd_stall = 1'b0;
  logic res_ready, upd_valid, upd_taken, upd_meta_en, upd_meta_inc, clr_valid, busy;
  logic [IP_W-1:0] upd_ip;
  logic [TIDX-1:0] clr_idx;
  logic [15:0] stat_upd, stat_misp;

  always #5 CLOCK_50 = ~CLOCK_50;

  predictor_update_sched #(.DEPTH(DEPTH), .IP_W(IP_W), .TABLE_IDX(TIDX)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
    .res_valid(res_valid), .res_ip(res_ip), .res_taken(res_taken), .res_pl(res_pl),
    .res_pg(res_pg), .res_pred(res_pred), .res_ready(res_ready),
    .flush_req(flush_req), .upd_stall(upd_stall),
    .upd_valid(upd_valid), .upd_ip(upd_ip), .upd_taken(upd_taken),
    .upd_meta_en(upd_meta_en), .upd_meta_inc(upd_meta_inc),
    .clr_valid(clr_valid), .clr_idx(clr_idx), .busy(busy),
    .stat_upd(stat_upd), .stat_misp(stat_misp)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of pending updates, operating mode, sweep position, stats.
  typedef struct { logic [15:0] ip; logic taken, men, minc; } ent_t;
  ent_t q[$];
  int mode, cidx, s_upd, s_misp;

  typedef struct {
    logic rv; logic [15:0] ip; logic t, pl, pg, pred, fl, st;
    logic e_rdy, e_uv; logic [15:0] e_ip;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic rv, logic [15:0] ip, logic t, logic pl, logic pg, logic pred,
                              logic fl, logic st, logic e_rdy, logic e_uv, logic [15:0] e_ip);
    vec_t v;
    v.rv = rv; v.ip = ip; v.t = t; v.pl = pl; v.pg = pg; v.pred = pred; v.fl = fl; v.st = st;
    v.e_rdy = e_rdy; v.e_uv = e_uv; v.e_ip = e_ip;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(logic rv, logic [15:0] ip, logic t, logic pl, logic pg, logic pred,
                        logic fl, logic st);
    res_valid = rv; res_ip = ip; res_taken = t; res_pl = pl; res_pg = pg; res_pred = pred;
    flush_req = fl; upd_stall = st;
  endtask

  task automatic model_reset();
    q.delete(); mode = M_CLR; cidx = 0; s_upd = 0; s_misp = 0;
  endtask

  task automatic cmp_all();
    logic e_uv;
    e_uv = (mode != M_CLR) && (q.size() > 0);
    chk("res_ready", res_ready, (mode == M_RUN) && (q.size() < DEPTH));
    chk("upd_valid", upd_valid, e_uv);
    if (e_uv) begin
      chk("upd_ip", upd_ip, q[0].ip);
      chk("upd_taken", upd_taken, q[0].taken);
      chk("upd_meta_en", upd_meta_en, q[0].men);
      chk("upd_meta_inc", upd_meta_inc, q[0].minc);
    end
    chk("clr_valid", clr_valid, mode == M_CLR);
    chk("clr_idx", clr_idx, cidx);
    chk("busy", busy, mode != M_RUN);
`ifdef PRED_UPD_STATS_EN
    chk("stat_upd", stat_upd, s_upd);
    chk("stat_misp", stat_misp, s_misp);
`else
    chk("stat_upd", stat_upd, 0);
    chk("stat_misp", stat_misp, 0);
`endif
  endtask

  task automatic model_step();
    int sz;
    bit push, pop;
    ent_t e;
    sz   = q.size();
    push = res_valid && (mode == M_RUN) && (sz < DEPTH);
    pop  = (mode != M_CLR) && (sz > 0) && !upd_stall;
    if (pop) begin
      void'(q.pop_front());
      if (s_upd < 65535) s_upd++;
    end
    if (push) begin
      e.ip = res_ip; e.taken = res_taken; e.men = (res_pl != res_pg); e.minc = (res_pg == res_taken);
      q.push_back(e);
      if (res_pred != res_taken && s_misp < 65535) s_misp++;
    end
    case (mode)
      M_CLR: if (cidx == NCLR - 1) begin mode = M_RUN; cidx = 0; end else cidx++;
      M_RUN: if (flush_req) mode = M_DRN;
      default: if (sz == 0) mode = M_CLR;
    endcase
  endtask

  // Called at posedge+1 with inputs set; compares at the falling edge, then advances.
  task automatic cyc();
    #4;
    cmp_all();
    model_step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic run_until_run(int limit);
    int n;
    n = 0;
    while (mode != M_RUN && n < limit) begin cyc(); n++; end
    if (mode != M_RUN) chk("run_timeout", n, limit + 1);
  endtask

  task automatic do_reset(int hold);
    RESET_N = 1'b0;
    #1;
    model_reset();
    cmp_all();
    repeat (hold) @(posedge CLOCK_50);
    #1;
    cmp_all();
    RESET_N = 1'b1;
  endtask

  initial begin
    int nclr;
    model_reset();
    @(posedge CLOCK_50); #1;
    do_reset(2);

    // Post-reset sweep: indices 0..15 on consecutive cycles, then RUN.
    for (int i = 0; i < NCLR; i++) begin
      #4;
      chk("sweep_idx", clr_idx, i);
      chk("sweep_valid", clr_valid, 1'b1);
      cmp_all();
      model_step();
      @(posedge CLOCK_50); #1;
    end

    // Directed table: single update, then stalled fill to full and ordered drain.
    tbl.push_back(mk(1, 16'h0040, 1, 0, 1, 1, 0, 1, 1, 0, 16'h0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 1, 1, 1, 16'h0040));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0040));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0));
    tbl.push_back(mk(1, 16'h1000, 1, 1, 1, 1, 0, 1, 1, 0, 16'h0));
    tbl.push_back(mk(1, 16'h2002, 0, 1, 0, 1, 0, 1, 1, 1, 16'h1000));
    tbl.push_back(mk(1, 16'h3004, 1, 0, 0, 0, 0, 1, 1, 1, 16'h1000));
    tbl.push_back(mk(1, 16'h4006, 0, 0, 1, 0, 0, 1, 1, 1, 16'h1000));
    tbl.push_back(mk(1, 16'h5008, 1, 1, 0, 1, 0, 1, 0, 1, 16'h1000));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1, 16'h1000));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 1, 16'h2002));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 1, 16'h3004));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 1, 16'h4006));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0));
    foreach (tbl[i]) begin
      set_in(tbl[i].rv, tbl[i].ip, tbl[i].t, tbl[i].pl, tbl[i].pg, tbl[i].pred, tbl[i].fl, tbl[i].st);
      #4;
      chk($sformatf("vec%0d_ready", i), res_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_uvalid", i), upd_valid, tbl[i].e_uv);
      if (tbl[i].e_uv) chk($sformatf("vec%0d_ip", i), upd_ip, tbl[i].e_ip);
      if (i == 0) chk("vec0_busy", busy, 1'b0);
      cmp_all();
      model_step();
      @(posedge CLOCK_50); #1;
    end

    // Flush with two queued entries: drain them, then a full clear sweep.
    set_in(1, 16'hA0A0, 1, 0, 0, 1, 0, 1); cyc();
    set_in(1, 16'hB0B0, 0, 1, 1, 0, 0, 1); cyc();
    set_in(0, 16'h0, 0, 0, 0, 0, 1, 1);    cyc();
    set_in(0, 16'h0, 0, 0, 0, 0, 0, 0);
    #4; chk("drain_ready", res_ready, 1'b0); chk("drain_busy", busy, 1'b1);
    cmp_all(); model_step(); @(posedge CLOCK_50); #1;
    nclr = 0;
    for (int i = 0; i < 40 && mode != M_RUN; i++) begin
      if (mode == M_CLR) nclr++;
      cyc();
    end
    chk("flush_clear_cycles", nclr, NCLR);
    chk("flush_back_to_run", mode, M_RUN);

    // Reset mid-sweep at clr_idx 7, then sweep restarts at 0.
    set_in(0, 16'h0, 0, 0, 0, 0, 1, 0); cyc();
    set_in(0, 16'h0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40 && !(mode == M_CLR && cidx == 7); i++) cyc();
    chk("reach_idx7", cidx, 7);
    do_reset(1);
    chk("reset_clr_idx", clr_idx, 0);
    for (int i = 0; i < 3; i++) begin
      #4; chk("restart_idx", clr_idx, i); cmp_all(); model_step(); @(posedge CLOCK_50); #1;
    end
    run_until_run(40);

    // Statistics: 3 mispredicted and 2 correct pushes, all retired.
    set_in(1, 16'h0100, 1, 0, 0, 0, 0, 0); cyc();
    set_in(1, 16'h0104, 0, 1, 0, 1, 0, 0); cyc();
    set_in(1, 16'h0108, 1, 1, 1, 1, 0, 0); cyc();
    set_in(1, 16'h010C, 0, 0, 1, 1, 0, 0); cyc();
    set_in(1, 16'h0110, 0, 0, 0, 0, 0, 0); cyc();
    set_in(0, 16'h0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    #4;
`ifdef PRED_UPD_STATS_EN
    chk("stat_misp_final", stat_misp, 3);
    chk("stat_upd_final", stat_upd, 5);
`else
    chk("stat_misp_final", stat_misp, 0);
    chk("stat_upd_final", stat_upd, 0);
`endif
    @(posedge CLOCK_50); #1;

    // Random traffic against the model, with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 6, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 3);
      cyc();
    end
    set_in(0, 16'h0, 0, 0, 0, 0, 0, 0);
    run_until_run(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
